// File: rtl/demux_sequencer_pkg.sv
// demux_sequencer_pkg: shared state encoding and channel count for the demux sequencer
package demux_sequencer_pkg;
  localparam int NCH = 4;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEEK = 2'd1,
    SEND = 2'd2,
    GAP  = 2'd3
  } state_t;
endpackage

// File: rtl/demux_sequencer_if.sv
// demux_sequencer_if: valid/ready serial bit stream into the sequencer
interface demux_sequencer_if;
  logic in_bit;
  logic in_valid;
  logic in_ready;
  modport master (output in_bit, output in_valid, input in_ready);
  modport slave (input in_bit, input in_valid, output in_ready);
endinterface

// File: rtl/demux_sequencer_rr_pick4.sv
// rr_pick4: first set mask bit after last, scanning round-robin over four channels
module rr_pick4
  import demux_sequencer_pkg::*;
(
  input  logic [NCH-1:0] mask,
  input  logic [1:0]     last,
  output logic [1:0]     next,
  output logic           found
);
  // Descending scan so the nearest candidate after last wins.
  always_comb begin
    next = last;
    for (int i = NCH; i >= 1; i--)
      if (mask[last + 2'(i)]) next = last + 2'(i);
  end
  assign found = |mask;
endmodule

// File: rtl/demux_sequencer.sv
// demux_sequencer: slices a serial stream into per-channel slots and drives the 4-way demux
module demux_sequencer
  import demux_sequencer_pkg::*;
#(
  parameter int SLOT_BITS  = 8,
  parameter int GAP_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [NCH-1:0]    ch_mask,
  demux_sequencer_if.slave  stream,
  output logic [1:0]        selector,
  output logic              signal,
  output logic              strobe,
  output logic              slot_start,
  output logic              busy
);
  localparam int CNT_W = $clog2(SLOT_BITS + GAP_CYCLES + 1);
  state_t state, state_n;
  logic [1:0] last_ch, pick;
  logic [CNT_W-1:0] bit_cnt, gap_cnt;
  logic found, load, xfer, last_bit, gap_done;
  rr_pick4 u_pick (.mask(ch_mask), .last(last_ch), .next(pick), .found(found));
  assign last_bit = bit_cnt == CNT_W'(SLOT_BITS - 1);
  assign gap_done = gap_cnt == CNT_W'(GAP_CYCLES - 1);
  assign stream.in_ready = state == SEND;
  assign busy = state != IDLE;
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  end
  always_comb begin
    load = state == SEEK && en && found;
    xfer = state == SEND && stream.in_valid;
    state_n = state;
    case (state)
      IDLE: state_n = en && found ? SEEK : IDLE;
      SEEK: state_n = load ? SEND : IDLE;
      SEND: state_n = xfer && last_bit ? (GAP_CYCLES > 0 ? GAP : SEEK) : SEND;
      GAP:  state_n = gap_done ? SEEK : GAP;
    endcase
  end
  // last_ch resets to 3 so the first round-robin scan begins at channel 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      selector   <= 2'd0;
      last_ch    <= 2'd3;
      signal     <= 1'b0;
      strobe     <= 1'b0;
      slot_start <= 1'b0;
      bit_cnt    <= '0;
      gap_cnt    <= '0;
    end else begin
      strobe     <= xfer;
      slot_start <= load;
      if (load) begin
        selector <= pick;
        last_ch  <= pick;
      end
      if (xfer) signal <= stream.in_bit;
      bit_cnt <= load || (xfer && last_bit) ? '0 : bit_cnt + CNT_W'(xfer);
      gap_cnt <= state == GAP && !gap_done ? gap_cnt + CNT_W'(1) : '0;
    end
  end
endmodule

// File: tb/tb_demux_sequencer.sv
// tb_demux_sequencer: table, hand-sequence and randomized scoreboard checks of demux_sequencer
module tb_demux_sequencer;
  import demux_sequencer_pkg::*;
  localparam int SB = 8;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n, en, rst_n_b, en_b;
  logic [3:0] ch_mask, mask_b;
  logic [1:0] sel_a, sel_b;
  logic sig_a, stb_a, ss_a, busy_a, sig_b, stb_b, ss_b, busy_b;
  demux_sequencer_if s_a ();
  demux_sequencer_if s_b ();
  demux_sequencer #(.SLOT_BITS(SB), .GAP_CYCLES(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .ch_mask(ch_mask), .stream(s_a),
    .selector(sel_a), .signal(sig_a), .strobe(stb_a), .slot_start(ss_a), .busy(busy_a));
  demux_sequencer #(.SLOT_BITS(SB), .GAP_CYCLES(0)) dut_b (
    .clk(clk), .rst_n(rst_n_b), .en(en_b), .ch_mask(mask_b), .stream(s_b),
    .selector(sel_b), .signal(sig_b), .strobe(stb_b), .slot_start(ss_b), .busy(busy_b));

  int checks = 0, errors = 0;
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference round-robin rule: first enabled channel after the previous one.
  function automatic logic [1:0] rr(logic [3:0] m, logic [1:0] l);
    for (int k = 1; k <= 4; k++)
      if (m[(l + k) % 4]) return 2'((l + k) % 4);
    return l;
  endfunction

  // Scoreboard for dut_a: accepted bits queue up and must come back in order on strobes.
  logic q[$];
  int cnt = -1, slots = 0;
  logic [1:0] m_last = 2'd3, cur_ch = 2'd0;
  logic [3:0] prev_mask = 4'd0;
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      cnt = -1;
      m_last = 2'd3;
    end else begin
      if (stb_a) begin
        chk("strobe_has_bit", q.size() > 0, 1);
        if (q.size() > 0) chk("signal_bit", sig_a, q.pop_front());
        chk("strobe_sel", sel_a, cur_ch);
        cnt++;
      end
      if (ss_a) begin
        if (cnt >= 0) chk("slot_len", cnt, SB);
        cur_ch = rr(prev_mask, m_last);
        m_last = cur_ch;
        cnt = 0;
        slots++;
        chk("slot_sel", sel_a, cur_ch);
      end
      if (s_a.in_valid && s_a.in_ready) q.push_back(s_a.in_bit);
    end
    prev_mask = ch_mask;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ss(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!ss_a && n < 100);
    chk("slot_start_seen", ss_a, 1);
  endtask

  typedef struct packed {
    logic [3:0]      mask;
    logic [3:0][1:0] seq;
  } vec_t;
  vec_t vecs[6];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    vecs[0] = '{4'b1111, {2'd3, 2'd2, 2'd1, 2'd0}};
    vecs[1] = '{4'b1010, {2'd3, 2'd1, 2'd3, 2'd1}};
    vecs[2] = '{4'b0100, {2'd2, 2'd2, 2'd2, 2'd2}};
    vecs[3] = '{4'b1001, {2'd3, 2'd0, 2'd3, 2'd0}};
    vecs[4] = '{4'b0110, {2'd2, 2'd1, 2'd2, 2'd1}};
    vecs[5] = '{4'b1000, {2'd3, 2'd3, 2'd3, 2'd3}};
    rst_n = 0; en = 0; ch_mask = 0; s_a.in_valid = 0; s_a.in_bit = 0;
    rst_n_b = 0; en_b = 0; mask_b = 0; s_b.in_valid = 0; s_b.in_bit = 0;
    tick(); tick();
    chk("rst_sel", sel_a, 0);
    chk("rst_signal", sig_a, 0);
    chk("rst_strobe", stb_a, 0);
    chk("rst_slot_start", ss_a, 0);
    chk("rst_in_ready", s_a.in_ready, 0);
    chk("rst_busy", busy_a, 0);
    // Full mask, constant valid: 0,1,2,3,0 with 10-cycle slot spacing.
    ch_mask = 4'hF; en = 1; s_a.in_valid = 1; s_a.in_bit = 1; rst_n = 1;
    wait_ss(n);
    chk("first_latency", n, 2);
    chk("first_sel", sel_a, 0);
    for (int k = 1; k <= 4; k++) begin
      wait_ss(n);
      chk("slot_period", n, SB + 2);
      chk("rr_sel", sel_a, k % 4);
    end
    repeat (SB) tick();
    chk("last_strobe_in_gap", {stb_a, s_a.in_ready, busy_a, sel_a}, {3'b101, 2'd0});
    tick();
    chk("seek_cycle", {stb_a, ss_a, s_a.in_ready, busy_a}, 4'b0001);
    tick();
    chk("next_slot", {ss_a, sel_a}, {1'b1, 2'd1});
    // Table: selector order for each mask from a fresh reset.
    for (int i = 0; i < 6; i++) begin
      rst_n = 0;
      tick();
      ch_mask = vecs[i].mask;
      rst_n = 1;
      for (int k = 0; k < 4; k++) begin
        wait_ss(n);
        chk($sformatf("tbl%0d_sel%0d", i, k), sel_a, vecs[i].seq[k]);
      end
    end
    // Random stalls, data and mask/enable changes against the scoreboard.
    ch_mask = 4'hF;
    for (int c = 0; c < 800; c++) begin
      s_a.in_valid = $urandom_range(0, 3) != 0;
      s_a.in_bit = 1'($urandom);
      if (c % 60 == 59) begin
        ch_mask = 4'($urandom_range(1, 15));
        en = $urandom_range(0, 5) != 0;
      end
      tick();
    end
    chk("random_progress", slots > 30, 1);
    // Mask cleared mid-slot: slot finishes, then the sequencer goes idle.
    en = 1; ch_mask = 4'b0011; s_a.in_valid = 1;
    wait_ss(n);
    tick(); tick();
    ch_mask = 4'b0000;
    n = 0;
    do begin
      tick();
      n++;
    end while (busy_a && n < 40);
    chk("idle_after_clear", {busy_a, s_a.in_ready}, 2'b00);
    chk("final_slot_len", cnt, SB);
    chk("queue_drained", q.size(), 0);
    repeat (3) tick();
    chk("stays_idle", busy_a, 0);
    // Reset after three bits of the third slot.
    ch_mask = 4'hF; rst_n = 0;
    tick();
    rst_n = 1; s_a.in_bit = 1;
    wait_ss(n); wait_ss(n); wait_ss(n);
    chk("slot2_sel", sel_a, 2);
    repeat (3) tick();
    chk("pre_reset_signal", sig_a, 1);
    rst_n = 0;
    tick();
    chk("midslot_reset", {sel_a, sig_a, stb_a, ss_a, s_a.in_ready, busy_a}, 7'd0);
    rst_n = 1;
    wait_ss(n);
    chk("post_reset_latency", n, 2);
    chk("post_reset_sel", sel_a, 0);
    // No-gap instance, single channel: SEND then one SEEK cycle per slot.
    rst_n_b = 1; en_b = 1; mask_b = 4'b0100; s_b.in_valid = 1; s_b.in_bit = 1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!ss_b && n < 100);
    chk("b_first_latency", n, 2);
    for (int k = 0; k < 3; k++) begin
      repeat (SB) tick();
      chk("b_last_strobe", {stb_b, sel_b, busy_b, s_b.in_ready, ss_b}, {1'b1, 2'd2, 3'b100});
      tick();
      chk("b_slot_start", {ss_b, stb_b, sel_b, s_b.in_ready}, {2'b10, 2'd2, 1'b1});
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
